// File: rtl/fnn_cfg_pkg.sv
// Shared types and width helpers for the neuron weight/bias configuration bus.
package fnn_cfg_pkg;

    localparam int CFG_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BIAS,
        WEIGHT,
        FINISH
    } loader_state_t;

    function automatic int neuron_cnt_w(input int max_neurons);
        return $clog2(max_neurons + 1);
    endfunction

    function automatic int weight_cnt_w(input int max_weights);
        return $clog2(max_weights + 1);
    endfunction

endpackage

// File: rtl/fnn_weight_loader.sv
// Sequences a host word stream onto the shared neuron config bus:
// per neuron one bias word, then weight_count weight words.
module fnn_weight_loader
    import fnn_cfg_pkg::*;
#(
    parameter int MAX_NEURONS = 64,
    parameter int MAX_WEIGHTS = 1024,
    parameter int NEURON_BASE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [CFG_WORD_W-1:0]                 layer_num,
    input  logic [neuron_cnt_w(MAX_NEURONS)-1:0]  neuron_count,
    input  logic [weight_cnt_w(MAX_WEIGHTS)-1:0]  weight_count,
    input  logic [CFG_WORD_W-1:0]                 s_data,
    input  logic                                  s_valid,
    input  logic                                  s_last,
    output logic                                  s_ready,
    output logic                                  weightValid,
    output logic [CFG_WORD_W-1:0]                 weightValue,
    output logic                                  biasValid,
    output logic [CFG_WORD_W-1:0]                 biasValue,
    output logic [CFG_WORD_W-1:0]                 config_layer_num,
    output logic [CFG_WORD_W-1:0]                 config_neuron_num,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  frame_err
);

    localparam int NCW = neuron_cnt_w(MAX_NEURONS);
    localparam int WCW = weight_cnt_w(MAX_WEIGHTS);

    loader_state_t         state_reg, state_next;
    logic [CFG_WORD_W-1:0] layer_reg;
    logic [NCW-1:0]        ncount_reg;
    logic [WCW-1:0]        wcount_reg;
    logic [NCW-1:0]        neuron_cnt_reg, neuron_cnt_next;
    logic [WCW-1:0]        weight_cnt_reg, weight_cnt_next;
    logic                  frame_err_reg, frame_err_next;

    logic                  bias_valid_reg, weight_valid_reg, done_reg;
    logic [CFG_WORD_W-1:0] bias_value_reg, weight_value_reg;
    logic [CFG_WORD_W-1:0] cfg_layer_reg, cfg_neuron_reg;

    logic accept, start_ok, last_weight, last_neuron;
    logic [WCW-1:0] weight_cnt_inc;
    logic [NCW-1:0] neuron_cnt_inc;

    assign s_ready        = (state_reg == BIAS) || (state_reg == WEIGHT);
    assign accept         = s_valid && s_ready;
    assign start_ok       = start && (neuron_count != '0) && (weight_count != '0);
    assign weight_cnt_inc = weight_cnt_reg + 1'b1;
    assign neuron_cnt_inc = neuron_cnt_reg + 1'b1;
    assign last_weight    = (weight_cnt_inc == wcount_reg);
    assign last_neuron    = (neuron_cnt_inc == ncount_reg);

    always_comb begin
        state_next      = state_reg;
        neuron_cnt_next = neuron_cnt_reg;
        weight_cnt_next = weight_cnt_reg;
        frame_err_next  = frame_err_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next      = BIAS;
                    neuron_cnt_next = '0;
                    weight_cnt_next = '0;
                    frame_err_next  = 1'b0;
                end
            end
            BIAS: begin
                // A bias word is never the last word of a layer, so s_last here is always early.
                if (accept) begin
                    if (s_last) begin
                        frame_err_next = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        state_next = WEIGHT;
                    end
                end
            end
            WEIGHT: begin
                if (accept) begin
                    weight_cnt_next = last_weight ? '0 : weight_cnt_inc;
                    if (last_weight && last_neuron) begin
                        state_next = FINISH;
                        if (!s_last) frame_err_next = 1'b1;
                    end else if (s_last) begin
                        frame_err_next = 1'b1;
                        state_next     = IDLE;
                    end else if (last_weight) begin
                        neuron_cnt_next = neuron_cnt_inc;
                        state_next      = BIAS;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            layer_reg      <= '0;
            ncount_reg     <= '0;
            wcount_reg     <= '0;
            neuron_cnt_reg <= '0;
            weight_cnt_reg <= '0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            neuron_cnt_reg <= neuron_cnt_next;
            weight_cnt_reg <= weight_cnt_next;
            frame_err_reg  <= frame_err_next;
            if (state_reg == IDLE && start_ok) begin
                layer_reg  <= layer_num;
                ncount_reg <= neuron_count;
                wcount_reg <= weight_count;
            end
        end
    end

    // Strobes, data and config fields all register on the accepting edge; fields hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_valid_reg   <= 1'b0;
            weight_valid_reg <= 1'b0;
            bias_value_reg   <= '0;
            weight_value_reg <= '0;
            cfg_layer_reg    <= '0;
            cfg_neuron_reg   <= '0;
            done_reg         <= 1'b0;
        end else begin
            bias_valid_reg   <= accept && (state_reg == BIAS);
            weight_valid_reg <= accept && (state_reg == WEIGHT);
            done_reg         <= (state_reg == FINISH);
            if (accept) begin
                cfg_layer_reg  <= layer_reg;
                cfg_neuron_reg <= CFG_WORD_W'(NEURON_BASE) + CFG_WORD_W'(neuron_cnt_reg);
                if (state_reg == BIAS) bias_value_reg   <= s_data;
                else                   weight_value_reg <= s_data;
            end
        end
    end

    assign biasValid         = bias_valid_reg;
    assign biasValue         = bias_value_reg;
    assign weightValid       = weight_valid_reg;
    assign weightValue       = weight_value_reg;
    assign config_layer_num  = cfg_layer_reg;
    assign config_neuron_num = cfg_neuron_reg;
    assign busy              = (state_reg != IDLE);
    assign done              = done_reg;
    assign frame_err         = frame_err_reg;

endmodule

// File: tb/tb_fnn_weight_loader.sv
// Randomized bench for fnn_weight_loader against a word-index reference model.
module tb_fnn_weight_loader;

    localparam int MAXN = 8;
    localparam int MAXW = 16;
    localparam int BASE = 5;
    localparam int NCW  = $clog2(MAXN + 1);
    localparam int WCW  = $clog2(MAXW + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [31:0]    layer_num = '0;
    logic [NCW-1:0] neuron_count = '0;
    logic [WCW-1:0] weight_count = '0;
    logic [31:0]    s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           s_ready, weightValid, biasValid, busy, done, frame_err;
    logic [31:0]    weightValue, biasValue, config_layer_num, config_neuron_num;

    fnn_weight_loader #(
        .MAX_NEURONS(MAXN),
        .MAX_WEIGHTS(MAXW),
        .NEURON_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .layer_num(layer_num),
        .neuron_count(neuron_count), .weight_count(weight_count),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .weightValid(weightValid), .weightValue(weightValue),
        .biasValid(biasValid), .biasValue(biasValue),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_bias;
        logic [31:0] value;
        logic [31:0] neuron;
        logic [31:0] layer;
    } exp_t;

    exp_t exp_q[$];
    int   n_errors = 0;
    int   n_checks = 0;
    int   cyc = 0;
    int   last_strobe_cyc = -100;
    int   done_seen = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every strobe is matched against the next expected word from the model.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mon_en) begin
            if (done) begin
                done_seen++;
                check("done_latency", 32'(cyc - last_strobe_cyc), 32'd1);
            end
            if (weightValid || biasValid) begin
                check("single_strobe", 32'(weightValid & biasValid), 32'd0);
                check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 32'(biasValid), 32'(e.is_bias));
                    check("strobe_value", biasValid ? biasValue : weightValue, e.value);
                    check("neuron_num", config_neuron_num, e.neuron);
                    check("layer_num", config_layer_num, e.layer);
                end
                last_strobe_cyc = cyc;
            end
        end
    end

    task automatic pulse_start(input int layer, input int n, input int w);
        @(posedge clk); #1;
        start        = 1'b1;
        layer_num    = 32'(layer);
        neuron_count = NCW'(n);
        weight_count = WCW'(w);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // last_idx: word index carrying s_last (-1 = never). abort_after: reset after that many accepts (-1 = none).
    task automatic run_load(input int layer, input int n, input int w, input logic [31:0] base_word,
                            input int last_idx, input int pvalid, input int abort_after,
                            input bit intrude);
        int   total, n_acc, idx, budget;
        bit   early, intruded;
        exp_t e;
        total = n * (w + 1);
        early = (last_idx >= 0) && (last_idx < total - 1);
        n_acc = early ? last_idx + 1 : total;
        if (abort_after >= 0) n_acc = abort_after;
        for (int i = 0; i < n_acc; i++) begin
            e.is_bias = ((i % (w + 1)) == 0);
            e.value   = base_word + 32'(i);
            e.neuron  = 32'(BASE + i / (w + 1));
            e.layer   = 32'(layer);
            exp_q.push_back(e);
        end
        done_seen = 0;
        pulse_start(layer, n, w);
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        check("ferr_cleared", 32'(frame_err), 32'd0);
        idx = 0;
        budget = 0;
        intruded = 1'b0;
        while (idx < n_acc && budget < 4000) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (intrude && !intruded && idx == 2) begin
                start        = 1'b1;
                layer_num    = 32'd99;
                neuron_count = NCW'(1);
                weight_count = WCW'(1);
                intruded     = 1'b1;
            end
            s_valid = ($urandom_range(99) < 32'(pvalid));
            s_data  = base_word + 32'(idx);
            s_last  = (idx == last_idx);
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            budget++;
        end
        check("accept_budget", 32'(idx), 32'(n_acc));
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        if (abort_after >= 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("rst_strobes", {30'b0, weightValid, biasValid}, 32'd0);
            check("rst_values", weightValue | biasValue, 32'd0);
            check("rst_config", config_layer_num | config_neuron_num, 32'd0);
            check("rst_flags", {28'b0, s_ready, busy, done, frame_err}, 32'd0);
        end
        repeat (6) @(negedge clk);
        check("done_count", 32'(done_seen), (abort_after < 0 && !early) ? 32'd1 : 32'd0);
        check("frame_err", 32'(frame_err), (abort_after < 0 && last_idx != total - 1) ? 32'd1 : 32'd0);
        check("idle_flags", {30'b0, busy, s_ready}, 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        $display("load layer=%0d n=%0d w=%0d last=%0d pvalid=%0d abort=%0d accepted=%0d done=%0d",
                 layer, n, w, last_idx, pvalid, abort_after, idx, done_seen);
    endtask

    task automatic ignored_start(input int n, input int w, input logic [31:0] prev_layer);
        pulse_start(77, n, w);
        @(negedge clk);
        check("zero_start_busy", {30'b0, busy, s_ready}, 32'd0);
        check("zero_start_layer", config_layer_num, prev_layer);
        $display("ignored start n=%0d w=%0d busy=%0d", n, w, busy);
    endtask

    initial begin
        int n, w, p;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", {30'b0, weightValid, biasValid}, 32'd0);
        check("reset_values", weightValue | biasValue | config_layer_num | config_neuron_num, 32'd0);
        check("reset_flags", {28'b0, s_ready, busy, done, frame_err}, 32'd0);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        run_load(2, 3, 4, 32'h10, 14, 100, -1, 1'b0);   // basic
        run_load(2, 3, 4, 32'h10, 14, 50, -1, 1'b0);    // backpressure
        run_load(4, 2, 3, 32'h40, 4, 100, -1, 1'b0);    // early s_last
        run_load(5, 3, 4, 32'h60, 14, 100, 6, 1'b0);    // reset mid-load
        run_load(3, 3, 4, 32'h80, 14, 70, -1, 1'b0);    // fresh load after reset
        run_load(6, 2, 4, 32'hA0, 9, 100, -1, 1'b1);    // start while busy
        ignored_start(2, 0, 32'd6);
        ignored_start(0, 3, 32'd6);
        run_load(7, 2, 1, 32'hC0, 3, 100, -1, 1'b0);    // neuron 5,5,6,6
        run_load(8, 2, 2, 32'hD0, -1, 100, -1, 1'b0);   // final word without s_last
        run_load(9, MAXN, 1, 32'hE0, 2 * MAXN - 1, 80, -1, 1'b0);
        run_load(10, 1, MAXW, 32'hF0, MAXW, 80, -1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 4);
            w = $urandom_range(1, 6);
            p = $urandom_range(30, 100);
            run_load(20 + k, n, w, $urandom, n * (w + 1) - 1, p, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
